polyveck_addsub_seq: RTL

- Sequential, parametrised successor to the combinational K-polynomial vector adder.
- Adds or subtracts two polynomial vectors (K polys × N coeffs × CW bits) coefficient-wise, LANES coefficients per clock.
- Results are written into a registered output vector.
- Sits in the key-generation datapath wherever vector add/sub is needed (t = A·s1 + s2 and similar); trades latency for area.

---
 rtl/polyveck_addsub_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/polyveck_addsub_seq.sv
// Sequential K-polynomial vector adder/subtractor, LANES coefficients per beat.
// Optional modular reduction (result in [0, Q)) when MOD_REDUCE_EN is defined.
module polyveck_addsub_seq #(
  parameter int unsigned K     = 6,
  parameter int unsigned N     = 256,
  parameter int unsigned CW    = 32,
  parameter int unsigned LANES = 4,
  parameter int unsigned Q     = 8380417
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_sub,
  input  logic [K*N*CW-1:0] linear_u,
  input  logic [K*N*CW-1:0] linear_v,
  output logic [K*N*CW-1:0] linear_w,
  output logic              busy,
  output logic              done
);

  localparam int unsigned TOTAL = K * N * CW;
  localparam int unsigned B     = (K * N) / LANES;
  localparam int unsigned CNTW  = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned IW    = $clog2(TOTAL);

  if (N % LANES != 0) begin : g_bad_lanes
    $error("polyveck_addsub_seq: N must be a multiple of LANES");
  end
  if (Q == 0) begin : g_bad_q
    $error("polyveck_addsub_seq: Q must be nonzero");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNTW-1:0]   r_cnt;
  logic              r_op;
  logic              r_busy;
  logic              r_done;
  logic [TOTAL-1:0]  r_w;
  logic              w_last;
  logic [IW-1:0]     w_base;
  logic [CW-1:0]     w_u   [LANES];
  logic [CW-1:0]     w_v   [LANES];
  logic [CW-1:0]     w_res [LANES];
`ifdef MOD_REDUCE_EN
  logic [CW:0]       w_ext [LANES];
`endif

  assign w_last = (r_cnt == CNTW'(B - 1));

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_FIN;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, beat counter, latched op, and registered status decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_RUN);
      r_done  <= (w_next_state == S_FIN);
      if (r_state == S_IDLE && start) begin
        r_op  <= op_sub;
        r_cnt <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= w_last ? '0 : r_cnt + CNTW'(1);
      end
    end
  end

  // Per-lane operand select and arithmetic for the current beat
  always_comb begin
    w_base = IW'(r_cnt) * IW'(LANES * CW);
    for (int l = 0; l < LANES; l++) begin
      w_u[l] = linear_u[w_base + IW'(l * CW) +: CW];
      w_v[l] = linear_v[w_base + IW'(l * CW) +: CW];
`ifdef MOD_REDUCE_EN
      w_ext[l] = r_op ? ({1'b0, w_u[l]} - {1'b0, w_v[l]})
                      : ({1'b0, w_u[l]} + {1'b0, w_v[l]});
      // Bit CW of the difference is the borrow: result went negative
      if (r_op)
        w_res[l] = w_ext[l][CW] ? CW'(w_ext[l] + (CW+1)'(Q)) : w_ext[l][CW-1:0];
      else
        w_res[l] = (w_ext[l] >= (CW+1)'(Q)) ? CW'(w_ext[l] - (CW+1)'(Q))
                                             : w_ext[l][CW-1:0];
`else
      w_res[l] = r_op ? (w_u[l] - w_v[l]) : (w_u[l] + w_v[l]);
`endif
    end
  end

  // Result vector: only the current beat's coefficients are rewritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_w <= '0;
    end else if (r_state == S_RUN) begin
      for (int l = 0; l < LANES; l++) begin
        r_w[w_base + IW'(l * CW) +: CW] <= w_res[l];
      end
    end
  end

  assign linear_w = r_w;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
